// File: rtl/router_switch_allocator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Port codes, port indices and shared types for the 3-port
//               router (x, y, local) switch allocator and crossbar.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

   // Crossbar select / destination codes (shared with the crossbar)
   localparam logic [1:0] PORT_NONE  = 2'b00;
   localparam logic [1:0] PORT_X     = 2'b01;
   localparam logic [1:0] PORT_Y     = 2'b10;
   localparam logic [1:0] PORT_LOCAL = 2'b11;

   // Port indices into the per-port vectors
   localparam int IDX_X     = 0;
   localparam int IDX_Y     = 1;
   localparam int IDX_LOCAL = 2;
   localparam int NUM_PORTS = 3;

   // Crossbar data width
   localparam int FLIT_W = 40;

   // Per-output wormhole state
   typedef enum logic [0:0] {
      OUT_IDLE   = 1'b0,
      OUT_LOCKED = 1'b1
   } out_state_e;

   // Input index (0..2) to select code (01..11)
   function automatic logic [1:0] idx2code(input logic [1:0] idx);
      return idx + 2'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/router_switch_allocator_if.sv
`default_nettype none
// ============================================================================
// Module      : router_switch_allocator_if
// Description : Request/grant bundle between the input FIFOs, the downstream
//               ready flags and the switch allocator.
//               master = FIFO/downstream side, slave = allocator.
// Revision    : 1.0 - initial release
// ============================================================================
interface router_switch_allocator_if;
   import router_pkg::*;

   logic [NUM_PORTS-1:0]   in_valid;
   logic [2*NUM_PORTS-1:0] in_dest;
   logic [NUM_PORTS-1:0]   in_tail;
   logic [NUM_PORTS-1:0]   out_ready;
   logic [1:0]             control_x;
   logic [1:0]             control_y;
   logic [1:0]             control_local;
   logic [NUM_PORTS-1:0]   in_pop;
   logic [NUM_PORTS-1:0]   out_valid;
   logic                   len_err;

   modport master (
      output in_valid, in_dest, in_tail, out_ready,
      input  control_x, control_y, control_local, in_pop, out_valid, len_err
   );

   modport slave (
      input  in_valid, in_dest, in_tail, out_ready,
      output control_x, control_y, control_local, in_pop, out_valid, len_err
   );

endinterface
`default_nettype wire

// File: rtl/router_switch_allocator_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter3
// Description : 3-request rotating-priority arbiter. The search starts one
//               past the last winner; with RR_EN=0 it is fixed x > y > local.
//               The pointer moves to the winner whenever a grant is issued.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter3
   import router_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   input  wire logic [2:0] req_i,
   output logic      [2:0] gnt_o,
   output logic      [1:0] gnt_idx_o
);

   logic [1:0] ptr_q;
   logic [1:0] ptr_d;
   logic [1:0] start_ptr;
   logic [2:0] gnt_d;
   logic [1:0] idx_d;
   logic [2:0] sum;
   logic [1:0] cand;
   logic       found;

   // Fixed priority is a round-robin search pinned to "last winner = local"
   assign start_ptr = RR_EN ? ptr_q : 2'(IDX_LOCAL);

   // Scan ptr+1, ptr+2, ptr (mod 3) and take the first requester
   always_comb begin
      gnt_d = '0;
      idx_d = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 1; k <= 3; k++) begin
         sum  = {1'b0, start_ptr} + 3'(k);
         cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
         if (!found && req_i[cand]) begin
            found = 1'b1;
            gnt_d = 3'b001 << cand;
            idx_d = cand;
         end
      end
   end

   assign ptr_d = found ? idx_d : ptr_q;

   // Pointer register; reset to local so x is searched first
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= 2'(IDX_LOCAL);
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign gnt_o     = gnt_d;
   assign gnt_idx_o = idx_d;

endmodule
`default_nettype wire

// File: rtl/router_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : router_switch_allocator
// Description : Wormhole switch allocator for the 3-port router crossbar.
//               Each output arbitrates idle head flits, then stays locked to
//               the winning input until its tail pops or the packet exceeds
//               MAX_PKT_LEN flits (forced release with a len_err pulse).
//               Selects and pops are combinational (FWFT FIFOs); out_valid
//               and len_err are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module router_switch_allocator
   import router_pkg::*;
#(
   parameter bit RR_EN       = 1'b1,
   parameter int MAX_PKT_LEN = 16
) (
   input wire logic                  clk,
   input wire logic                  rst_n,
   router_switch_allocator_if.slave  bus
);

   // Count value at which a further non-tail pop overflows the packet
   localparam logic [7:0] CNT_LAST = 8'(MAX_PKT_LEN - 1);

   logic [2:0] in_valid_w;
   logic [5:0] in_dest_w;
   logic [2:0] in_tail_w;
   logic [2:0] out_ready_w;

   logic [2:0] locked_w;   // output o is LOCKED
   logic [5:0] owner_w;    // owner index of output o at [2o+:2]
   logic [2:0] busy_w;     // input i owns some output
   logic [5:0] ctrl_w;     // select code of output o at [2o+:2]
   logic [8:0] pop_w;      // pop request from output o at [3o+:3]
   logic [2:0] force_w;    // output o forces a release this cycle

   logic [2:0] out_valid_q;
   logic       len_err_q;

   assign in_valid_w  = bus.in_valid;
   assign in_dest_w   = bus.in_dest;
   assign in_tail_w   = bus.in_tail;
   assign out_ready_w = bus.out_ready;

   // An input is busy while any output is locked to it
   always_comb begin
      busy_w = '0;
      for (int o = 0; o < 3; o++) begin
         if (locked_w[o]) begin
            busy_w[owner_w[2*o +: 2]] = 1'b1;
         end
      end
   end

   for (genvar o = 0; o < 3; o++) begin : g_out
      localparam logic [1:0] OUT_CODE = 2'(o + 1);

      out_state_e state_q, state_d;
      logic [1:0] owner_q, owner_d;
      logic [7:0] cnt_q, cnt_d;
      logic [2:0] cand;
      logic [2:0] req;
      logic [2:0] gnt;
      logic [1:0] gnt_idx;
      logic       grant;
      logic       fire;
      logic [1:0] ctrl_raw;
      logic [2:0] pop_raw;
      logic       forced;

      // Head flits addressed here from inputs not already holding a lock
      always_comb begin
         cand = '0;
         for (int i = 0; i < 3; i++) begin
            cand[i] = in_valid_w[i] && (in_dest_w[2*i +: 2] == OUT_CODE) && !busy_w[i];
         end
      end

      // Arbitrate only while idle and downstream can take the flit
      assign req = ((state_q == OUT_IDLE) && out_ready_w[o]) ? cand : 3'b000;

      rr_arbiter3 #(
         .RR_EN (RR_EN)
      ) u_arb (
         .clk       (clk),
         .rst_n     (rst_n),
         .req_i     (req),
         .gnt_o     (gnt),
         .gnt_idx_o (gnt_idx)
      );

      assign grant = |gnt;
      assign fire  = (state_q == OUT_LOCKED) && in_valid_w[owner_q] && out_ready_w[o];

      // Select code, pop strobe and next wormhole state for this output
      always_comb begin
         state_d  = state_q;
         owner_d  = owner_q;
         cnt_d    = cnt_q;
         ctrl_raw = PORT_NONE;
         pop_raw  = '0;
         forced   = 1'b0;
         if (state_q == OUT_IDLE) begin
            if (grant) begin
               ctrl_raw         = idx2code(gnt_idx);
               pop_raw[gnt_idx] = 1'b1;
               // A single-flit packet leaves the output idle
               if (!in_tail_w[gnt_idx]) begin
                  state_d = OUT_LOCKED;
                  owner_d = gnt_idx;
                  cnt_d   = 8'd1;
               end
            end
         end else if (fire) begin
            ctrl_raw         = idx2code(owner_q);
            pop_raw[owner_q] = 1'b1;
            if (in_tail_w[owner_q]) begin
               state_d = OUT_IDLE;
               cnt_d   = 8'd0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = OUT_IDLE;
               cnt_d   = 8'd0;
               forced  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
      end

      // Wormhole state registers; reset drops any lock silently
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            state_q <= OUT_IDLE;
            owner_q <= 2'd0;
            cnt_q   <= 8'd0;
         end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
         end
      end

      assign locked_w[o]        = (state_q == OUT_LOCKED);
      assign owner_w[2*o +: 2]  = owner_q;
      assign ctrl_w[2*o +: 2]   = rst_n ? ctrl_raw : PORT_NONE;
      assign pop_w[3*o +: 3]    = rst_n ? pop_raw : 3'b000;
      assign force_w[o]         = forced;
   end

   // Inputs have a single destination, so the OR never merges two grants
   assign bus.in_pop        = pop_w[2:0] | pop_w[5:3] | pop_w[8:6];
   assign bus.control_x     = ctrl_w[1:0];
   assign bus.control_y     = ctrl_w[3:2];
   assign bus.control_local = ctrl_w[5:4];

   // out_valid tracks the crossbar output register; len_err pulses once
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 3'b000;
         len_err_q   <= 1'b0;
      end else begin
         out_valid_q <= {|ctrl_w[5:4], |ctrl_w[3:2], |ctrl_w[1:0]};
         len_err_q   <= |force_w;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.len_err   = len_err_q;

endmodule
`default_nettype wire

// File: tb/tb_router_switch_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_switch_allocator
// Description : Self-checking bench for router_switch_allocator. Two DUTs
//               share the stimulus: dut_rr (round-robin, 16-flit limit) and
//               dut_fx (fixed priority, 4-flit limit). A packet-level model
//               predicts both every cycle; directed vectors pin exact values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_switch_allocator;
   import router_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] t_valid;
   logic [5:0] t_dest;
   logic [2:0] t_tail;
   logic [2:0] t_ready;

   int errors = 0;
   int checks = 0;

   router_switch_allocator_if if_rr ();
   router_switch_allocator_if if_fx ();

   assign if_rr.in_valid  = t_valid;
   assign if_rr.in_dest   = t_dest;
   assign if_rr.in_tail   = t_tail;
   assign if_rr.out_ready = t_ready;
   assign if_fx.in_valid  = t_valid;
   assign if_fx.in_dest   = t_dest;
   assign if_fx.in_tail   = t_tail;
   assign if_fx.out_ready = t_ready;

   router_switch_allocator #(.RR_EN(1'b1), .MAX_PKT_LEN(16)) dut_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_rr)
   );

   router_switch_allocator #(.RR_EN(1'b0), .MAX_PKT_LEN(4)) dut_fx (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if_fx)
   );

   always #5 clk = ~clk;

   // Reference model: per DUT, per output owner (-1 = free), flit count and
   // last granted input; registered out_valid / len_err
   int         m_own [2][3];
   int         m_cnt [2][3];
   int         m_last[2][3];
   logic [2:0] m_ov  [2];
   logic       m_le  [2];
   int         n_own [2][3];
   int         n_cnt [2][3];
   int         n_last[2][3];
   logic [2:0] n_ov  [2];
   logic       n_le  [2];
   logic [5:0] e_ctrl[2];
   logic [2:0] e_pop [2];
   logic [5:0] a_ctrl[2];
   logic [2:0] a_pop [2];
   logic [2:0] a_ov  [2];
   logic       a_le  [2];

   function automatic void chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic bit owns(input int d, input int i);
      for (int o = 0; o < 3; o++) begin
         if (m_own[d][o] == i) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int o = 0; o < 3; o++) begin
            m_own[d][o]  = -1;
            m_cnt[d][o]  = 0;
            m_last[d][o] = 2;
         end
         m_ov[d] = 3'b000;
         m_le[d] = 1'b0;
      end
   endtask

   task automatic model_eval(input int d);
      int  maxlen;
      bit  rr;
      int  pick;
      int  i;
      maxlen   = (d == 0) ? 16 : 4;
      rr       = (d == 0);
      e_ctrl[d] = '0;
      e_pop[d]  = '0;
      n_le[d]   = 1'b0;
      for (int o = 0; o < 3; o++) begin
         n_own[d][o]  = m_own[d][o];
         n_cnt[d][o]  = m_cnt[d][o];
         n_last[d][o] = m_last[d][o];
      end
      if (rst_n !== 1'b1) begin
         for (int o = 0; o < 3; o++) begin
            n_own[d][o]  = -1;
            n_cnt[d][o]  = 0;
            n_last[d][o] = 2;
         end
      end else begin
         for (int o = 0; o < 3; o++) begin
            if (m_own[d][o] >= 0) begin
               i = m_own[d][o];
               if (t_valid[i] && t_ready[o]) begin
                  e_ctrl[d][2*o +: 2] = 2'(i + 1);
                  e_pop[d][i] = 1'b1;
                  if (t_tail[i]) begin
                     n_own[d][o] = -1;
                     n_cnt[d][o] = 0;
                  end else if (m_cnt[d][o] == maxlen - 1) begin
                     n_own[d][o] = -1;
                     n_cnt[d][o] = 0;
                     n_le[d]     = 1'b1;
                  end else begin
                     n_cnt[d][o] = m_cnt[d][o] + 1;
                  end
               end
            end else if (t_ready[o]) begin
               pick = -1;
               for (int s = 0; s < 3; s++) begin
                  i = rr ? (m_last[d][o] + 1 + s) % 3 : s;
                  if (pick < 0 && t_valid[i] && int'(t_dest[2*i +: 2]) == o + 1 && !owns(d, i))
                     pick = i;
               end
               if (pick >= 0) begin
                  e_ctrl[d][2*o +: 2] = 2'(pick + 1);
                  e_pop[d][pick] = 1'b1;
                  n_last[d][o]   = pick;
                  if (!t_tail[pick]) begin
                     n_own[d][o] = pick;
                     n_cnt[d][o] = 1;
                  end
               end
            end
         end
      end
      for (int o = 0; o < 3; o++) n_ov[d][o] = (e_ctrl[d][2*o +: 2] != 2'b00);
      if (rst_n !== 1'b1) n_ov[d] = 3'b000;
   endtask

   task automatic drive(input logic r, input logic [2:0] v, input logic [5:0] dst,
                        input logic [2:0] tl, input logic [2:0] rd);
      rst_n   = r;
      t_valid = v;
      t_dest  = dst;
      t_tail  = tl;
      t_ready = rd;
   endtask

   // One clock: sample at the falling edge, compare to the model, then advance
   task automatic cycle();
      @(negedge clk);
      model_eval(0);
      model_eval(1);
      a_ctrl[0] = {if_rr.control_local, if_rr.control_y, if_rr.control_x};
      a_ctrl[1] = {if_fx.control_local, if_fx.control_y, if_fx.control_x};
      a_pop[0]  = if_rr.in_pop;
      a_pop[1]  = if_fx.in_pop;
      a_ov[0]   = if_rr.out_valid;
      a_ov[1]   = if_fx.out_valid;
      a_le[0]   = if_rr.len_err;
      a_le[1]   = if_fx.len_err;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("model_ctrl[%0d]", d), 8'(a_ctrl[d]), 8'(e_ctrl[d]));
         chk($sformatf("model_pop[%0d]", d),  8'(a_pop[d]),  8'(e_pop[d]));
         chk($sformatf("model_ov[%0d]", d),   8'(a_ov[d]),   8'(m_ov[d]));
         chk($sformatf("model_le[%0d]", d),   8'(a_le[d]),   8'(m_le[d]));
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         for (int o = 0; o < 3; o++) begin
            m_own[d][o]  = n_own[d][o];
            m_cnt[d][o]  = n_cnt[d][o];
            m_last[d][o] = n_last[d][o];
         end
         m_ov[d] = n_ov[d];
         m_le[d] = n_le[d];
      end
   endtask

   typedef struct {
      logic [2:0] v;
      logic [5:0] dst;
      logic [2:0] tl;
      logic [2:0] rd;
      logic [5:0] ec;
      logic [2:0] ep;
      logic [2:0] eov;
   } vec_t;

   vec_t tbl[10];

   // Hand-written sequence storage
   logic [2:0] sv_v [8];
   logic [5:0] sv_d [8];
   logic [2:0] sv_t [8];
   logic [2:0] sv_r [8];
   logic [5:0] sv_ec[8];
   logic [2:0] sv_ep[8];
   int         hits;

   initial begin
      // Single-flit x->y, then 3-way contention for local (dut_rr)
      tbl[0] = '{3'b001, 6'b00_00_10, 3'b001, 3'b111, 6'b00_01_00, 3'b001, 3'b000};
      tbl[1] = '{3'b000, 6'b00_00_00, 3'b000, 3'b111, 6'b00_00_00, 3'b000, 3'b010};
      tbl[2] = '{3'b111, 6'b11_11_11, 3'b111, 3'b111, 6'b01_00_00, 3'b001, 3'b000};
      tbl[3] = '{3'b111, 6'b11_11_11, 3'b111, 3'b111, 6'b10_00_00, 3'b010, 3'b100};
      tbl[4] = '{3'b111, 6'b11_11_11, 3'b111, 3'b111, 6'b11_00_00, 3'b100, 3'b100};
      tbl[5] = '{3'b111, 6'b11_11_11, 3'b111, 3'b111, 6'b01_00_00, 3'b001, 3'b100};
      tbl[6] = '{3'b111, 6'b11_11_11, 3'b111, 3'b111, 6'b10_00_00, 3'b010, 3'b100};
      tbl[7] = '{3'b111, 6'b11_11_11, 3'b111, 3'b111, 6'b11_00_00, 3'b100, 3'b100};
      tbl[8] = '{3'b000, 6'b00_00_00, 3'b000, 3'b111, 6'b00_00_00, 3'b000, 3'b100};
      tbl[9] = '{3'b000, 6'b00_00_00, 3'b000, 3'b111, 6'b00_00_00, 3'b000, 3'b000};

      model_reset();
      drive(1'b0, 3'b000, 6'b0, 3'b000, 3'b111);
      cycle();
      // Reset forces selects and pops low even with live requests
      drive(1'b0, 3'b111, 6'b11_10_01, 3'b111, 3'b111);
      cycle();
      chk("reset_ctrl", 8'(a_ctrl[0]), 8'h00);
      chk("reset_pop", 8'(a_pop[0]), 8'h00);
      drive(1'b1, 3'b000, 6'b0, 3'b000, 3'b111);
      cycle();
      chk("reset_ov", 8'(a_ov[0]), 8'h00);
      chk("reset_le", 8'(a_le[0]), 8'h00);

      for (int k = 0; k < 10; k++) begin
         drive(1'b1, tbl[k].v, tbl[k].dst, tbl[k].tl, tbl[k].rd);
         cycle();
         chk($sformatf("tbl%0d_ctrl", k), 8'(a_ctrl[0]), 8'(tbl[k].ec));
         chk($sformatf("tbl%0d_pop", k),  8'(a_pop[0]),  8'(tbl[k].ep));
         chk($sformatf("tbl%0d_ov", k),   8'(a_ov[0]),   8'(tbl[k].eov));
      end

      // Wormhole: y holds x for head/body/body/tail while local waits
      sv_v[0] = 3'b110; sv_t[0] = 3'b100; sv_ec[0] = 6'b00_00_10; sv_ep[0] = 3'b010;
      sv_v[1] = 3'b110; sv_t[1] = 3'b100; sv_ec[1] = 6'b00_00_10; sv_ep[1] = 3'b010;
      sv_v[2] = 3'b110; sv_t[2] = 3'b100; sv_ec[2] = 6'b00_00_10; sv_ep[2] = 3'b010;
      sv_v[3] = 3'b110; sv_t[3] = 3'b110; sv_ec[3] = 6'b00_00_10; sv_ep[3] = 3'b010;
      sv_v[4] = 3'b100; sv_t[4] = 3'b100; sv_ec[4] = 6'b00_00_11; sv_ep[4] = 3'b100;
      sv_v[5] = 3'b000; sv_t[5] = 3'b000; sv_ec[5] = 6'b00_00_00; sv_ep[5] = 3'b000;
      hits = 0;
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, sv_v[k], 6'b01_01_00, sv_t[k], 3'b111);
         cycle();
         if (a_ctrl[0][1:0] == 2'b10) hits++;
         chk($sformatf("worm%0d_ctrl", k), 8'(a_ctrl[0]), 8'(sv_ec[k]));
         chk($sformatf("worm%0d_pop", k),  8'(a_pop[0]),  8'(sv_ep[k]));
      end
      chk("worm_y_flits", 8'(hits), 8'd4);

      // Backpressure: x->local stalls three cycles mid-packet
      for (int k = 0; k < 8; k++) begin
         sv_v[k] = 3'b001; sv_t[k] = 3'b000; sv_r[k] = 3'b111;
         sv_ec[k] = 6'b01_00_00; sv_ep[k] = 3'b001;
      end
      for (int k = 2; k < 5; k++) begin
         sv_r[k] = 3'b011; sv_ec[k] = 6'b00_00_00; sv_ep[k] = 3'b000;
      end
      sv_t[6] = 3'b001;
      sv_v[7] = 3'b000; sv_ec[7] = 6'b00_00_00; sv_ep[7] = 3'b000;
      hits = 0;
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, sv_v[k], 6'b00_00_11, sv_t[k], sv_r[k]);
         cycle();
         if (a_pop[0][0]) hits++;
         chk($sformatf("bp%0d_ctrl", k), 8'(a_ctrl[0]), 8'(sv_ec[k]));
         chk($sformatf("bp%0d_pop", k),  8'(a_pop[0]),  8'(sv_ep[k]));
      end
      chk("bp_flits", 8'(hits), 8'd4);

      // Length overflow on dut_fx (limit 4): five non-tail flits, then tail
      hits = 0;
      for (int k = 0; k < 7; k++) begin
         drive(1'b1, (k < 6) ? 3'b001 : 3'b000, 6'b00_00_10, (k == 5) ? 3'b001 : 3'b000, 3'b111);
         cycle();
         if (a_le[1]) hits++;
         chk($sformatf("len%0d_le", k), 8'(a_le[1]), (k == 4) ? 8'd1 : 8'd0);
         chk($sformatf("len%0d_ctrl", k), 8'(a_ctrl[1]), (k < 6) ? 8'h04 : 8'h00);
      end
      chk("len_pulses", 8'(hits), 8'd1);

      // Reset mid-packet: x locked on y, then reset, then x and y contend
      drive(1'b1, 3'b001, 6'b00_00_10, 3'b000, 3'b111);
      cycle();
      drive(1'b1, 3'b001, 6'b00_00_10, 3'b000, 3'b111);
      cycle();
      drive(1'b0, 3'b011, 6'b00_10_10, 3'b000, 3'b111);
      cycle();
      chk("rst_mid_ctrl", 8'(a_ctrl[0]), 8'h00);
      chk("rst_mid_pop", 8'(a_pop[0]), 8'h00);
      drive(1'b1, 3'b011, 6'b00_10_10, 3'b011, 3'b111);
      cycle();
      chk("rst_after_ctrl", 8'(a_ctrl[0]), 8'h04);
      chk("rst_after_pop", 8'(a_pop[0]), 8'h01);
      chk("rst_after_ov", 8'(a_ov[0]), 8'h00);
      drive(1'b1, 3'b010, 6'b00_10_00, 3'b010, 3'b111);
      cycle();
      chk("rst_next_ctrl", 8'(a_ctrl[0]), 8'h08);
      chk("rst_next_pop", 8'(a_pop[0]), 8'h02);

      // Random traffic, short packets then long packets
      for (int n = 0; n < 4000; n++) begin
         logic [2:0] tl;
         logic [2:0] rd;
         for (int b = 0; b < 3; b++) begin
            tl[b] = (n < 2500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 31) == 0);
            rd[b] = ($urandom_range(0, 3) != 0);
         end
         drive(($urandom_range(0, 99) != 0), 3'($urandom), 6'($urandom), tl, rd);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/router_switch_allocator.md
Name: router_switch_allocator

Overview:
Switch allocator for the 3-port (x, y, local) router crossbar. It arbitrates head-flit requests from the three input FIFOs for the three output paths and drives the crossbar's 2-bit per-output select codes. It generates FIFO pop strobes and output-valid flags. Wormhole switching: once a head flit wins an output, that output stays locked to the winning input until the tail flit passes.

Parameters:
RR_EN, 1, 1 = per-output round-robin; 0 = fixed priority x > y > local
MAX_PKT_LEN, 16, maximum flits per packet including head and tail; exceeding it forces release (range 2..255)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  3  input FIFO non-empty; bit0 x, bit1 y, bit2 local
in_dest  in  6  requested output of the FIFO head flit, 2 bits per input (bits[1:0] x, [3:2] y, [5:4] local); meaningful only on head flits
in_tail  in  3  FIFO head flit is a tail flit; a single-flit packet has head and tail set together
out_ready  in  3  downstream can accept a flit on output x/y/local
control_x  out  2  crossbar select for output x: 00 none, 01 x, 10 y, 11 local
control_y  out  2  crossbar select for output y, same encoding
control_local  out  2  crossbar select for output local, same encoding
in_pop  out  3  read enable to input FIFOs, one per input
out_valid  out  3  registered; flit present on crossbar output register
len_err  out  1  registered one-cycle pulse on forced release

Behaviour:
- Destination encoding equals select encoding: 01 x, 10 y, 11 local, 00 no request. U-turns are allowed.
- Per output o: state IDLE or LOCKED, 2-bit owner, round-robin pointer rr_ptr, flit counter cnt (8 bits).
- Per input: busy flag, set while that input owns any output. Busy inputs are excluded from IDLE arbitration, so body-flit dest bits are never decoded.
- IDLE arbitration:
  - Candidates are inputs i with in_valid[i], in_dest[i] equal to o's code, and busy[i] clear.
  - A grant is made only if out_ready[o] is high.
  - With RR_EN=1, search starts at rr_ptr+1 mod 3. With RR_EN=0, the order is x, y, local.
  - On grant: control_o = code of i, in_pop[i] = 1, rr_ptr <= i. If in_tail[i], stay IDLE. Otherwise go to LOCKED with owner = i, busy[i] set, cnt = 1.
- LOCKED behaviour:
  - When in_valid[owner] and out_ready[o]: control_o = owner code, in_pop[owner] = 1, cnt increments.
  - Otherwise control_o = 00 and no pop. Stalls are allowed indefinitely.
  - Popping a tail flit returns the output to IDLE and clears busy. The next head may win the same output on the following cycle.
  - Forced release: if a non-tail flit is popped when cnt = MAX_PKT_LEN-1, the output returns to IDLE, clears busy, and pulses len_err the next cycle. Subsequent flits from that input are treated as heads.
- Each input has a single destination, so an input is never granted by two outputs in one cycle. in_pop has at most one source per bit.
- control_* and in_pop are combinational from registered state plus current inputs (FWFT FIFOs). The crossbar captures the data on the same edge. out_valid[o] <= (control_o != 00), which aligns with the crossbar's 1-cycle register latency.
- Reset (rst_n low at a clk edge):
  - All outputs IDLE, busy cleared, cnt 0, rr_ptr = local so x has first priority, out_valid 0, len_err 0.
  - While rst_n is low, control_* are forced to 00 and in_pop to 000.
  - Reset mid-packet drops the lock with no error pulse.

Decomposition:
- Shared package router_pkg holds: PORT_NONE/PORT_X/PORT_Y/PORT_LOCAL 2-bit constants (shared with the crossbar), port index constants, and FLIT_W = 40.
- One sub-module, rr_arbiter3: a 3-request, 3-grant rotating-priority arbiter with registered pointer and a fixed-priority mode. It is instantiated once per output.

Test Plan:
- Single-flit packet: x valid, dest=10, tail=1, out_ready=111. Same cycle: control_y=01, in_pop=001. Next cycle: out_valid=010. Output y stays IDLE.
- Contention: x, y, local all dest=11, tail=1, held valid 6 cycles, RR_EN=1. control_local grant sequence is 01,10,11,01,10,11.
- Wormhole lock: y sends head (dest 01), body, body, then tail on x. Meanwhile local requests x. Local is granted only the cycle after y's tail pops; control_x=10 for exactly 4 popped flits.
- Backpressure: locked x→local, out_ready[2]=0 for 3 cycles mid-packet. control_local=00 and in_pop[0]=0 during the stall; the lock is held and resumes with no flit lost.
- Length overflow: MAX_PKT_LEN=4, x sends 5 non-tail flits to y. len_err pulses once after the 4th pop. The 5th flit is arbitrated as a new head.
- Reset mid-packet: rst_n=0 for 1 cycle while locked. control_*=00 and in_pop=000 during reset. All outputs IDLE afterwards; a fresh head on x wins first.
